// File: rtl/jk_op_arbiter.sv
// ============================================================================
// Module      : jk_op_arbiter
// Description : Round-robin arbiter and sequencer sharing one external JK
//               flip-flop between NUM_REQ requesters. Each granted operation
//               drives j/k for exactly one clock, samples the resulting q one
//               cycle later and returns it tagged with the requester ID.
//               Optional feature macro: JK_OP_ARBITER_CHECK_EN enables an
//               internal JK model whose disagreement with q raises rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active low
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 j,
    output logic                 k,
    input  logic                 q,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_q,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_q_q, rsp_q_d;
    logic               busy_q, busy_d;

    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic               w_grant;
    logic [1:0]         w_win_op;
    logic [NUM_REQ-1:0] w_onehot;
    int                 w_cand;

    // Round-robin search starting one past the last winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_cand   = 0;
        for (int s = 1; s <= NUM_REQ; s++) begin
            w_cand = (int'(ptr_q) + s) % NUM_REQ;
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'(w_cand);
            end
        end
    end

    // Grant only while idle and out of reset; ready is a one-hot of the winner.
    always_comb begin
        w_grant  = (state_q == S_IDLE) && w_found && rst;
        w_win_op = req_op[{w_win_id, 1'b0} +: 2];
        w_onehot = '0;
        if (w_grant) begin
            w_onehot[w_win_id] = 1'b1;
        end
    end

    assign req_ready = w_onehot;

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        j_d         = 1'b0;
        k_d         = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant) begin
                    ptr_d   = w_win_id;
                    id_d    = w_win_id;
                    j_d     = w_win_op[1];
                    k_d     = w_win_op[0];
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // j/k return to hold after their single active cycle
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // q now reflects the op applied at the end of DRIVE
                rsp_q_d     = q;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= c_PTR_RST;
            id_q        <= '0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            j_q         <= j_d;
            k_q         <= k_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            busy_q      <= busy_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign busy      = busy_q;

`ifdef JK_OP_ARBITER_CHECK_EN
    logic qm_q, qm_d;
    logic rsp_err_q, rsp_err_d;

    // Shadow JK model: advance on the driven op, compare and resync on sample.
    always_comb begin
        qm_d      = qm_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            S_DRIVE: begin
                case ({j_q, k_q})
                    2'b00:   qm_d = qm_q;
                    2'b01:   qm_d = 1'b0;
                    2'b10:   qm_d = 1'b1;
                    default: qm_d = ~qm_q;
                endcase
            end
            S_SETTLE: begin
                rsp_err_d = (q != qm_q);
                qm_d      = q;
            end
            default: begin
                qm_d = qm_q;
            end
        endcase
    end

    // Model registers share the block reset; flip-flop also resets to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qm_q      <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            qm_q      <= qm_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire
